// File: rtl/pll_dyn_ctrl.sv
`timescale 1ns/1ps
// Reference-clock-side controller for a dynamically reconfigurable PLL: drives the divider selects
// and RESET, then qualifies LOCK through a synchronizer, a consecutive-high filter, a timeout and bounded retries.
module pll_dyn_ctrl #(
    parameter logic [5:0] DEF_IDIV     = 6'd3,
    parameter logic [5:0] DEF_FBDIV    = 6'd54,
    parameter logic [5:0] DEF_ODSEL    = 6'h3F,
    parameter int         RST_CYCLES   = 16,
    parameter int         LOCK_FILTER  = 64,
    parameter int         LOCK_TIMEOUT = 65535,
    parameter int         RETRY_MAX    = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [5:0] cfg_idiv,
    input  logic [5:0] cfg_fbdiv,
    input  logic [5:0] cfg_odsel,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       locked,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAIL   = 2'd3
    } state_e;

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int KW = $clog2(RETRY_MAX + 1);

    localparam logic [RW-1:0] RST_LAST   = RW'(RST_CYCLES - 1);
    localparam logic [RW-1:0] RST_MAX    = RW'(RST_CYCLES);
    localparam logic [FW-1:0] FILT_LAST  = FW'(LOCK_FILTER - 1);
    localparam logic [FW-1:0] FILT_MAX   = FW'(LOCK_FILTER);
    localparam logic [TW-1:0] TMO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX    = TW'(LOCK_TIMEOUT);
    localparam logic [KW-1:0] RETRY_LAST = KW'(RETRY_MAX - 1);
    localparam logic [KW-1:0] RETRY_SAT  = KW'(RETRY_MAX);

    state_e        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [KW-1:0] retry_cnt_q, retry_cnt_d;
    logic [5:0]    idsel_q, idsel_d, fbdsel_q, fbdsel_d, odsel_q, odsel_d;
    logic          pll_reset_q, pll_reset_d, locked_q, locked_d, busy_q, busy_d;
    logic          err_q, err_d, cfg_ready_q, cfg_ready_d;
    logic          lock_s, accept_s, filt_done_s, timeout_s;

    assign lock_s      = sync_q[1];
    assign accept_s    = cfg_valid & cfg_ready_q;
    assign filt_done_s = lock_s & (filt_cnt_q == FILT_LAST);
    assign timeout_s   = (tmo_cnt_q == TMO_LAST);

    // Two-flop synchronizer shift for the asynchronous PLL lock
    always_comb begin
        sync_d = {sync_q[0], pll_lock};
    end

    // Next-state decision; in WAIT a completed filter takes priority over a timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: begin
                if (rst_cnt_q >= RST_LAST) state_d = ST_WAIT;
                else                       state_d = ST_RESET;
            end
            ST_WAIT: begin
                if (filt_done_s)                    state_d = ST_LOCKED;
                else if (timeout_s && (retry_cnt_q >= RETRY_LAST)) state_d = ST_FAIL;
                else if (timeout_s)                 state_d = ST_RESET;
                else                                state_d = ST_WAIT;
            end
            ST_LOCKED: begin
                if (accept_s)     state_d = ST_RESET;
                else if (!lock_s) state_d = ST_WAIT;
                else              state_d = ST_LOCKED;
            end
            ST_FAIL: begin
                if (accept_s) state_d = ST_RESET;
                else          state_d = ST_FAIL;
            end
            default: state_d = ST_RESET;
        endcase
    end

    // Saturating counters, retry bookkeeping and divider select capture
    always_comb begin
        rst_cnt_d   = {RW{1'b0}};
        filt_cnt_d  = {FW{1'b0}};
        tmo_cnt_d   = {TW{1'b0}};
        retry_cnt_d = retry_cnt_q;
        case (state_q)
            ST_RESET: begin
                if ((state_d == ST_RESET) && (rst_cnt_q != RST_MAX)) rst_cnt_d = rst_cnt_q + RW'(1);
                else if (state_d == ST_RESET)                        rst_cnt_d = rst_cnt_q;
                else                                                 rst_cnt_d = {RW{1'b0}};
            end
            ST_WAIT: begin
                if (state_d == ST_WAIT) begin
                    tmo_cnt_d = (tmo_cnt_q != TMO_MAX) ? tmo_cnt_q + TW'(1) : tmo_cnt_q;
                    if (lock_s) filt_cnt_d = (filt_cnt_q != FILT_MAX) ? filt_cnt_q + FW'(1) : filt_cnt_q;
                    else        filt_cnt_d = {FW{1'b0}};
                end else if (state_d == ST_LOCKED) begin
                    retry_cnt_d = {KW{1'b0}};
                end else begin
                    retry_cnt_d = (retry_cnt_q != RETRY_SAT) ? retry_cnt_q + KW'(1) : retry_cnt_q;
                end
            end
            ST_LOCKED: retry_cnt_d = {KW{1'b0}};
            ST_FAIL: begin
                if (accept_s) retry_cnt_d = {KW{1'b0}};
                else          retry_cnt_d = retry_cnt_q;
            end
            default: retry_cnt_d = {KW{1'b0}};
        endcase
        if (accept_s) begin
            idsel_d  = ~cfg_idiv;
            fbdsel_d = ~cfg_fbdiv;
            odsel_d  = cfg_odsel;
        end else begin
            idsel_d  = idsel_q;
            fbdsel_d = fbdsel_q;
            odsel_d  = odsel_q;
        end
    end

    // Status outputs decoded from the upcoming state so the registered copies track it exactly
    always_comb begin
        pll_reset_d = 1'b1;
        locked_d    = 1'b0;
        busy_d      = 1'b1;
        err_d       = 1'b0;
        cfg_ready_d = 1'b0;
        case (state_d)
            ST_RESET: begin
                pll_reset_d = 1'b1;
                busy_d      = 1'b1;
            end
            ST_WAIT: begin
                pll_reset_d = 1'b0;
                busy_d      = 1'b1;
            end
            ST_LOCKED: begin
                pll_reset_d = 1'b0;
                locked_d    = 1'b1;
                busy_d      = 1'b0;
                cfg_ready_d = 1'b1;
            end
            ST_FAIL: begin
                pll_reset_d = 1'b1;
                busy_d      = 1'b0;
                err_d       = 1'b1;
                cfg_ready_d = 1'b1;
            end
            default: begin
                pll_reset_d = 1'b1;
                busy_d      = 1'b1;
            end
        endcase
    end

    // State, counter and output registers; reset re-arms the boot attempt with default selects
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_RESET;
            sync_q      <= 2'b00;
            rst_cnt_q   <= {RW{1'b0}};
            filt_cnt_q  <= {FW{1'b0}};
            tmo_cnt_q   <= {TW{1'b0}};
            retry_cnt_q <= {KW{1'b0}};
            idsel_q     <= ~DEF_IDIV;
            fbdsel_q    <= ~DEF_FBDIV;
            odsel_q     <= DEF_ODSEL;
            pll_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            rst_cnt_q   <= rst_cnt_d;
            filt_cnt_q  <= filt_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            idsel_q     <= idsel_d;
            fbdsel_q    <= fbdsel_d;
            odsel_q     <= odsel_d;
            pll_reset_q <= pll_reset_d;
            locked_q    <= locked_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign pll_reset  = pll_reset_q;
    assign pll_idsel  = idsel_q;
    assign pll_fbdsel = fbdsel_q;
    assign pll_odsel  = odsel_q;
    assign locked     = locked_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign cfg_ready  = cfg_ready_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for pll_dyn_ctrl: table of reconfiguration vectors with a select scoreboard,
// plus hand-written sequences for boot, glitchy lock, lock loss, timeout/retry and mid-attempt reset.
module tb_pll_dyn_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n, cfg_valid, cfg_ready, pll_lock, pll_reset, locked, busy, err;
    logic [5:0] cfg_idiv, cfg_fbdiv, cfg_odsel, pll_idsel, pll_fbdsel, pll_odsel;
    logic       lock_mode, lock_force;

    typedef struct {
        logic [5:0] idiv, fbdiv, odsel, e_idsel, e_fbdsel, e_odsel;
    } vec_t;
    typedef struct {
        logic [5:0] idsel, fbdsel, odsel;
    } exp_t;

    vec_t vecs[4];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // PLL model: lock follows the inverse of RESET unless the test forces a value
    assign pll_lock = lock_mode ? lock_force : ~pll_reset;

    always #5 sys_clk = ~sys_clk;

    pll_dyn_ctrl #(
        .RST_CYCLES(4), .LOCK_FILTER(8), .LOCK_TIMEOUT(100), .RETRY_MAX(2)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_idiv(cfg_idiv), .cfg_fbdiv(cfg_fbdiv), .cfg_odsel(cfg_odsel),
        .pll_lock(pll_lock), .pll_reset(pll_reset),
        .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
        .locked(locked), .busy(busy), .err(err)
    );

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_pll_reset"}, int'(pll_reset), 1);
        chk({name, "_idsel"}, int'(pll_idsel), 32'h3C);
        chk({name, "_fbdsel"}, int'(pll_fbdsel), 32'h09);
        chk({name, "_odsel"}, int'(pll_odsel), 32'h3F);
        chk({name, "_locked"}, int'(locked), 0);
        chk({name, "_busy"}, int'(busy), 1);
        chk({name, "_err"}, int'(err), 0);
        chk({name, "_cfg_ready"}, int'(cfg_ready), 0);
    endtask

    // Current negedge is the first RESET cycle; count how many cycles pll_reset stays high
    task automatic measure_reset(output int n);
        n = 1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (pll_reset) n++;
            else break;
        end
    endtask

    task automatic wait_lock(input string name, output int c);
        c = 0;
        while (!locked && c < 300) begin
            tick();
            c++;
        end
        chk({name, "_locked"}, int'(locked), 1);
    endtask

    task automatic apply_req(input vec_t v, input string name);
        exp_t e;
        bit   acc;
        acc         = 1'b0;
        cfg_valid   = 1'b1;
        cfg_idiv    = v.idiv;
        cfg_fbdiv   = v.fbdiv;
        cfg_odsel   = v.odsel;
        e.idsel     = v.e_idsel;
        e.fbdsel    = v.e_fbdsel;
        e.odsel     = v.e_odsel;
        sb.push_back(e);
        for (int i = 0; i < 400 && !acc; i++) begin
            acc = cfg_ready;
            tick();
        end
        cfg_valid = 1'b0;
        chk({name, "_accepted"}, int'(acc), 1);
        e = sb.pop_front();
        chk({name, "_idsel"}, int'(pll_idsel), int'(e.idsel));
        chk({name, "_fbdsel"}, int'(pll_fbdsel), int'(e.fbdsel));
        chk({name, "_odsel"}, int'(pll_odsel), int'(e.odsel));
        chk({name, "_locked0"}, int'(locked), 0);
        chk({name, "_reset1"}, int'(pll_reset), 1);
        chk({name, "_ready0"}, int'(cfg_ready), 0);
        chk({name, "_err0"}, int'(err), 0);
        chk({name, "_busy1"}, int'(busy), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c, rs;
        vecs[0] = '{6'd1,  6'd9,  6'h3E, 6'h3E, 6'h36, 6'h3E};
        vecs[1] = '{6'd0,  6'd0,  6'h00, 6'h3F, 6'h3F, 6'h00};
        vecs[2] = '{6'd63, 6'd63, 6'h21, 6'h00, 6'h00, 6'h21};
        vecs[3] = '{6'd3,  6'd54, 6'h3F, 6'h3C, 6'h09, 6'h3F};

        sys_rst_n  = 1'b0;
        cfg_valid  = 1'b0;
        cfg_idiv   = 6'd0;
        cfg_fbdiv  = 6'd0;
        cfg_odsel  = 6'd0;
        lock_mode  = 1'b0;
        lock_force = 1'b0;
        repeat (3) tick();
        chk_reset_vals("rst");

        // Boot
        sys_rst_n = 1'b1;
        measure_reset(n);
        chk("boot_rst_width", n, 4);
        wait_lock("boot", c);
        chk("boot_latency_10_11", int'(c >= 10 && c <= 11), 1);
        chk("boot_ready", int'(cfg_ready), 1);
        chk("boot_busy", int'(busy), 0);

        // Table-driven reconfiguration
        for (int i = 0; i < 4; i++) begin
            apply_req(vecs[i], $sformatf("reconf%0d", i));
            measure_reset(n);
            chk($sformatf("reconf%0d_rst_width", i), n, 4);
            wait_lock($sformatf("reconf%0d", i), c);
            chk($sformatf("reconf%0d_latency", i), int'(c >= 10 && c <= 11), 1);
        end

        // Glitchy lock: 7 high, 1 low, then steady
        lock_mode  = 1'b1;
        lock_force = 1'b0;
        apply_req(vecs[0], "glitch");
        measure_reset(n);
        chk("glitch_rst_width", n, 4);
        c = 0;
        lock_force = 1'b1;
        while (!locked && c < 60) begin
            tick();
            c++;
            lock_force = (c != 7);
        end
        chk("glitch_locked", int'(locked), 1);
        chk("glitch_latency_18_19", int'(c >= 18 && c <= 19), 1);

        // Lock loss for one cycle in LOCKED
        rs = 0;
        c  = 0;
        lock_force = 1'b0;
        while (locked && c < 10) begin
            tick();
            c++;
            lock_force = 1'b1;
            if (pll_reset) rs++;
        end
        chk("loss_locked_fell", int'(locked), 0);
        chk("loss_fall_within3", int'(c <= 3), 1);
        while (!locked && c < 60) begin
            tick();
            c++;
            if (pll_reset) rs++;
        end
        chk("loss_relocked", int'(locked), 1);
        chk("loss_no_pll_reset", rs, 0);

        // Timeout and retry exhaustion
        lock_force = 1'b0;
        apply_req(vecs[1], "tmo");
        c  = 0;
        rs = 0;
        while (!err && c < 400) begin
            if (pll_reset) rs++;
            tick();
            c++;
        end
        chk("tmo_cycles_to_err", c, 208);
        chk("tmo_reset_cycles", rs, 8);
        chk("tmo_err", int'(err), 1);
        chk("tmo_pll_reset", int'(pll_reset), 1);
        chk("tmo_ready", int'(cfg_ready), 1);
        chk("tmo_busy", int'(busy), 0);
        chk("tmo_locked", int'(locked), 0);
        repeat (5) tick();
        chk("tmo_err_held", int'(err), 1);

        lock_mode = 1'b0;
        apply_req(vecs[2], "after_fail");
        measure_reset(n);
        chk("after_fail_rst_width", n, 4);
        wait_lock("after_fail", c);

        // Asynchronous reset during WAIT_LOCK after a reconfiguration
        lock_mode  = 1'b1;
        lock_force = 1'b0;
        apply_req(vecs[0], "mid");
        measure_reset(n);
        repeat (3) tick();
        chk("mid_in_wait_busy", int'(busy), 1);
        chk("mid_in_wait_reset", int'(pll_reset), 0);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_async");
        tick();
        sys_rst_n = 1'b1;
        lock_mode = 1'b0;
        measure_reset(n);
        chk("reboot_rst_width", n, 4);
        chk("reboot_idsel", int'(pll_idsel), 32'h3C);
        wait_lock("reboot", c);
        chk("reboot_latency", int'(c >= 10 && c <= 11), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_dyn_ctrl.md
Name: pll_dyn_ctrl

Overview:
- Control-side counterpart of the rPLL wrapper. Drives the PLL's dynamic divider selects (IDSEL/FBDSEL/ODSEL) and RESET, and consumes the PLL's LOCK.
- Sequences a boot configuration and later runtime reconfiguration requests, then qualifies lock with a filter, a timeout and bounded retries.
- Runs on the board reference clock (27 MHz), never on the PLL output.

Parameters:
DEF_IDIV, 3, boot input divider code (divider minus one)
DEF_FBDIV, 54, boot feedback divider code (divider minus one)
DEF_ODSEL, 6'h3F, boot ODSEL code, passed to PLL unmodified
RST_CYCLES, 16, cycles pll_reset is held high per attempt (>=1)
LOCK_FILTER, 64, consecutive synced-lock-high cycles required to declare lock (>=1)
LOCK_TIMEOUT, 65535, cycles in WAIT_LOCK before an attempt fails
RETRY_MAX, 3, failed attempts allowed before FAIL (>=1)

Ports:
sys_clk  in  1  reference clock
sys_rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  reconfiguration request
cfg_ready  out  1  request can be accepted
cfg_idiv  in  6  input divider code
cfg_fbdiv  in  6  feedback divider code
cfg_odsel  in  6  ODSEL code
pll_lock  in  1  PLL LOCK (asynchronous to sys_clk)
pll_reset  out  1  to PLL RESET
pll_idsel  out  6  to PLL IDSEL
pll_fbdsel  out  6  to PLL FBDSEL
pll_odsel  out  6  to PLL ODSEL
locked  out  1  qualified lock; downstream reset release
busy  out  1  attempt in progress
err  out  1  retries exhausted

Behaviour:
- Encoding: pll_idsel = ~idiv_code, pll_fbdsel = ~fbdiv_code (bitwise 6-bit inversion). pll_odsel = code as given.
- pll_lock passes through a 2-flop synchronizer; lock_s is the synced value.
- Reset values and state:
  - State RESET with counter 0.
  - pll_reset=1, pll_idsel=~DEF_IDIV (6'h3C), pll_fbdsel=~DEF_FBDIV (6'h09), pll_odsel=DEF_ODSEL.
  - locked=0, busy=1, err=0, cfg_ready=0, retry count 0.
  - The boot attempt therefore starts immediately on reset release.
- State RESET:
  - pll_reset=1, busy=1.
  - Stays exactly RST_CYCLES cycles, then goes to WAIT_LOCK; pll_reset=0 from the first WAIT_LOCK cycle.
- State WAIT_LOCK:
  - busy=1; filter and timeout counters both start at 0.
  - lock_s=1 increments the filter; lock_s=0 clears it.
  - Filter reaching LOCK_FILTER -> LOCKED.
  - Timeout reaching LOCK_TIMEOUT without lock:
    - retry+1; if retry == RETRY_MAX -> FAIL, else -> RESET (same selects).
  - If filter completion and timeout land on the same cycle, lock wins.
- State LOCKED:
  - locked=1, busy=0, cfg_ready=1, retry cleared on entry.
  - lock_s=0 for one cycle -> locked=0 next cycle, then WAIT_LOCK with fresh counters; no PLL reset unless timeout.
- State FAIL:
  - err=1, pll_reset=1, busy=0, cfg_ready=1, locked=0.
- Handshake:
  - Accepted on an edge where cfg_valid && cfg_ready.
  - Next cycle: selects hold the new codes, state is RESET, locked=0, err=0, retry=0, cfg_ready=0.
  - Requests while busy are not accepted; cfg_valid must be held until accepted.
  - Lock loss and a valid request on the same cycle in LOCKED: the request wins.
- Latency, reset release to locked=1 (lock steady): RST_CYCLES + (up to 2 sync) + LOCK_FILTER cycles.
- Async reset mid-attempt: immediately returns to reset values, discards runtime config and restarts the boot attempt.
- Counters saturate, never wrap. Counter widths sized from the parameters.

Test Plan:
(Use RST_CYCLES=4, LOCK_FILTER=8, LOCK_TIMEOUT=100, RETRY_MAX=2.)
- Boot:
  - Release sys_rst_n; pll_lock rises when pll_reset falls.
  - pll_reset high exactly 4 cycles; pll_idsel=6'h3C, pll_fbdsel=6'h09.
  - locked=1 at 10-11 cycles after pll_reset falls; cfg_ready=1.
- Reconfig:
  - In LOCKED, cfg_valid with idiv=1, fbdiv=9, odsel=6'h3E.
  - Next cycle: pll_idsel=6'h3E, pll_fbdsel=6'h36, pll_odsel=6'h3E, locked=0, pll_reset=1 for 4 cycles, then relock.
- Glitchy lock:
  - Lock high 7 cycles, low 1, then steady.
  - Filter restarts; locked asserts only after 8 consecutive synced-high cycles.
- Timeout/retry:
  - Lock never asserts.
  - Two attempts of 4 + 100 cycles, then err=1, pll_reset=1, cfg_ready=1.
  - A new request clears err and restarts.
- Lock loss:
  - Drop pll_lock for 1 cycle in LOCKED.
  - locked falls within 3 cycles, pll_reset stays 0, and lock is requalified without reset.
- Reset mid-WAIT_LOCK after a reconfig:
  - All outputs return to reset values (selects to defaults) asynchronously.
